// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the CPU load/store port.
// Serves one access at a time. Each access takes LATENCY busy cycles, and
// stall holds the pipeline until the access completes.
// Optional feature: define DMEM_READ_BUF_EN to build a one-entry read buffer.
// A read that hits the buffer completes in the same cycle, with no stall.
module dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        init,
  input  logic [15:0] DataAddress,
  input  logic        ReadMem,
  input  logic        WriteMem,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        stall,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT_CNT = 4'(LATENCY);
  localparam int         DEPTH   = 1 << ADDR_WIDTH;

  state_t                  state_reg;
  logic [3:0]              cnt_reg;
  logic [ADDR_WIDTH-1:0]   req_addr_reg;
  logic [15:0]             req_data_reg;
  logic                    req_write_reg;
  logic [15:0]             data_out_reg;
  logic                    mem_err_reg;
  logic [15:0]             mem_rd_reg;
  logic [15:0]             mem [0:DEPTH-1];

  logic                    request;
  logic                    start;
  logic                    last_busy;
  logic                    commit_write;
  logic [ADDR_WIDTH-1:0]   addr_in;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    buf_hit;
  logic [15:0]             buf_rd_data;

  // The upper address bits are deliberately dropped, so addresses wrap.
  generate
    if (ADDR_WIDTH < 16) begin : g_wrap
      logic unused_upper_addr;
      assign unused_upper_addr = ^DataAddress[15:ADDR_WIDTH];
    end
  endgenerate

  assign addr_in      = DataAddress[ADDR_WIDTH-1:0];
  assign request      = ReadMem | WriteMem;
  assign start        = request & ~buf_hit;
  assign last_busy    = (state_reg == BUSY) && (cnt_reg == LAT_CNT);
  assign commit_write = last_busy & req_write_reg & ~init;
  // Before capture, the read port follows the live address. This keeps the
  // read word ready at the first BUSY edge, which matters when LATENCY is 1.
  assign rd_addr      = (state_reg == IDLE) ? addr_in : req_addr_reg;

`ifdef DMEM_READ_BUF_EN
  logic                    buf_valid_reg;
  logic [ADDR_WIDTH-1:0]   buf_tag_reg;
  logic [15:0]             buf_data_reg;

  // A plain read in IDLE is a hit when it matches the valid buffered address.
  assign buf_hit = (state_reg == IDLE) && ReadMem && !WriteMem && !init &&
                   buf_valid_reg && (buf_tag_reg == addr_in);
  assign buf_rd_data = buf_data_reg;

  // Fill the buffer on read completion. A write to the tagged address updates
  // the buffer at the same edge as the array write.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      buf_valid_reg <= 1'b0;
      buf_tag_reg   <= '0;
      buf_data_reg  <= 16'h0000;
    end else if (last_busy) begin
      if (!req_write_reg) begin
        buf_valid_reg <= 1'b1;
        buf_tag_reg   <= req_addr_reg;
        buf_data_reg  <= mem_rd_reg;
      end else if (buf_valid_reg && (buf_tag_reg == req_addr_reg)) begin
        buf_data_reg  <= req_data_reg;
      end
    end
  end
`else
  assign buf_hit     = 1'b0;
  assign buf_rd_data = 16'h0000;
`endif

  // The memory array has no reset, so a reset does not disturb its contents.
  // The read port is registered and reloads every cycle.
  always_ff @(posedge clk) begin
    if (commit_write) begin
      mem[req_addr_reg] <= req_data_reg;
    end
    mem_rd_reg <= mem[rd_addr];
  end

  // Access sequencer: IDLE captures a request, BUSY counts the latency, and
  // DONE presents the result for one cycle.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      req_addr_reg  <= '0;
      req_data_reg  <= 16'h0000;
      req_write_reg <= 1'b0;
      data_out_reg  <= 16'h0000;
      mem_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (buf_hit) begin
            data_out_reg <= buf_rd_data;
          end
          if (start) begin
            req_addr_reg  <= addr_in;
            req_data_reg  <= DataIn;
            req_write_reg <= WriteMem;
            cnt_reg       <= 4'd1;
            state_reg     <= BUSY;
            if (ReadMem && WriteMem) begin
              mem_err_reg <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt_reg == LAT_CNT) begin
            state_reg <= DONE;
            if (!req_write_reg) begin
              data_out_reg <= mem_rd_reg;
            end
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Stall drops as soon as init is asserted, even while a request is held.
  assign stall   = ~init & (((state_reg == IDLE) & start) | (state_reg == BUSY));
  assign DataOut = buf_hit ? buf_rd_data : data_out_reg;
  assign mem_err = mem_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed, scoreboard-checked bench for dmem_responder.
module tb_dmem_responder;

  localparam int LAT        = 3;
  localparam int FULL_STALL = LAT + 1;
`ifdef DMEM_READ_BUF_EN
  localparam int HIT_STALL  = 0;
`else
  localparam int HIT_STALL  = LAT + 1;
`endif

  logic        clk = 1'b0;
  logic        init;
  logic [15:0] DataAddress;
  logic        ReadMem;
  logic        WriteMem;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        stall;
  logic        mem_err;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mdl_mem [0:255];
  logic [15:0] mdl_last;

  dmem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut (
    .clk(clk), .init(init), .DataAddress(DataAddress), .ReadMem(ReadMem),
    .WriteMem(WriteMem), .DataIn(DataIn), .DataOut(DataOut), .stall(stall),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one request and wait until stall drops. Then compare the stall count
  // and DataOut against the value queued when the request was driven.
  task automatic access(input string tag, input bit rd, input bit wr,
                        input logic [15:0] addr, input logic [15:0] data,
                        input int exp_stalls);
    int          stalls;
    bit          done;
    logic [15:0] exp_out;
    if (wr) begin
      mdl_mem[addr[7:0]] = data;
      exp_q.push_back(mdl_last);
    end else begin
      mdl_last = mdl_mem[addr[7:0]];
      exp_q.push_back(mdl_last);
    end
    DataAddress = addr; DataIn = data; ReadMem = rd; WriteMem = wr;
    stalls = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
        @(posedge clk); #1;
      end else begin
        done = 1;
      end
    end
    exp_out = exp_q.pop_front();
    if (!done) check({tag, "_timeout"}, 16'd1, 16'd0);
    check({tag, "_stalls"}, 16'(stalls), 16'(exp_stalls));
    check({tag, "_data"}, DataOut, exp_out);
    $display("txn %s rd=%0d wr=%0d addr=%h data=%h stalls=%0d DataOut=%h",
             tag, rd, wr, addr, data, stalls, DataOut);
    @(posedge clk); #1;
    ReadMem = 0; WriteMem = 0;
  endtask

  initial begin
    init = 1; DataAddress = 0; ReadMem = 0; WriteMem = 0; DataIn = 0;
    mdl_last = 16'h0000;
    repeat (2) @(posedge clk);
    #1 init = 0;
    @(negedge clk);
    check("rst_dataout", DataOut, 16'h0000);
    check("rst_stall", 16'(stall), 16'd0);
    check("rst_err", 16'(mem_err), 16'd0);
    @(posedge clk); #1;

    access("wr_beef", 0, 1, 16'h0012, 16'hBEEF, FULL_STALL);
    access("rd_beef", 1, 0, 16'h0012, 16'h0000, FULL_STALL);
    access("wr_wrap", 0, 1, 16'h0105, 16'h1234, FULL_STALL);
    access("rd_wrap", 1, 0, 16'h0005, 16'h0000, FULL_STALL);

    access("conflict", 1, 1, 16'h0020, 16'h00AA, FULL_STALL);
    check("err_set", 16'(mem_err), 16'd1);
    access("rd_conf", 1, 0, 16'h0020, 16'h0000, FULL_STALL);
    check("err_sticky", 16'(mem_err), 16'd1);

    // Reset in the second BUSY cycle of a write must abort the write.
    access("preload", 0, 1, 16'h0030, 16'h1111, FULL_STALL);
    DataAddress = 16'h0030; DataIn = 16'h5555; WriteMem = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    init = 1;
    #1;
    check("midrst_stall", 16'(stall), 16'd0);
    check("midrst_dataout", DataOut, 16'h0000);
    @(posedge clk); #1;
    WriteMem = 0; init = 0;
    mdl_last = 16'h0000;
    $display("txn midrst write 5555 to 0030 aborted by init");
    check("midrst_err", 16'(mem_err), 16'd0);
    access("rd_midrst", 1, 0, 16'h0030, 16'h0000, FULL_STALL);

    access("buf_rd1", 1, 0, 16'h0012, 16'h0000, FULL_STALL);
    access("buf_rd2", 1, 0, 16'h0012, 16'h0000, HIT_STALL);
    access("buf_wr", 0, 1, 16'h0012, 16'hCAFE, FULL_STALL);
    access("buf_rd3", 1, 0, 16'h0012, 16'h0000, HIT_STALL);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the CPU's load/store port. It is the memory end of the `DataAddress`/`ReadMem`/`WriteMem`/`DataIn`/`DataOut` interface that the execute stage drives. It services one request at a time with a fixed access latency and raises `stall` so the pipeline latches hold until the access completes. It replaces the zero-latency RAM model so that pipeline stall handling can be exercised.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: word-address bits; depth is 2^ADDR_WIDTH 16-bit words.
- `LATENCY`, default 3: number of BUSY cycles per access; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `init`  in  1  reset, asynchronous, active-high.
- `DataAddress`  in  16  word address; only bits `[ADDR_WIDTH-1:0]` are used, so upper bits wrap.
- `ReadMem`  in  1  load request.
- `WriteMem`  in  1  store request.
- `DataIn`  in  16  store data.
- `DataOut`  out  16  load data.
- `stall`  out  1  high while the request is not yet complete; the CPU holds its request and latches.
- `mem_err`  out  1  sticky flag: `ReadMem` and `WriteMem` were asserted together.

## Operation

The block is a three-state FSM: IDLE, BUSY, DONE.

- **IDLE**
  - A request is present when `ReadMem | WriteMem` is high.
  - With a request present, `stall` = 1 combinationally in the same cycle.
  - At the clock edge: capture address, data and op into `req_*` registers; load `cnt` = 1; go to BUSY.
  - With no request present: stay in IDLE, `stall` = 0.
- **BUSY**
  - `stall` = 1.
  - If `cnt == LATENCY`, go to DONE at the edge; otherwise increment `cnt`.
  - For a read, the array is read using the captured address.
  - For a write, the array is written at the BUSY→DONE edge using the captured address and data.
  - Input changes during BUSY are ignored; the captured values are used.
- **DONE**
  - `stall` = 0.
  - For a read, `DataOut` holds the read word, registered at the BUSY→DONE edge.
  - Go to IDLE unconditionally at the next edge. The request still asserted in this cycle belongs to the completed access and is not re-serviced.
- **Simultaneous `ReadMem` and `WriteMem`:** treated as a write; `mem_err` is set and stays set until `init`.
- **`DataOut`:** changes only on read completion (or on a buffer hit, see Configuration). Writes never alter it.
- **Memory array:** has no reset. Contents are undefined until written and are preserved across `init`.

## Timing

- **Reset values:** state = IDLE, `cnt` = 0, `DataOut` = 16'h0000, `stall` = 0 (or follows the IDLE request term), `mem_err` = 0.
- **Access cost:** a request first presented in cycle 0 sees `stall` = 1 for cycles 0..LATENCY (LATENCY+1 cycles). `stall` = 0 and data are valid in cycle LATENCY+1, and the CPU advances at the end of that cycle.
- **Throughput:** one access per LATENCY+2 cycles. A back-to-back request is recognised in the IDLE cycle that follows DONE.
- **`init` mid-operation:** the FSM returns to IDLE immediately and `stall` drops.
  - An in-flight write is not committed.
  - An in-flight read does not update `DataOut`.
- **`LATENCY` = 1:** a single BUSY cycle; 2 stall cycles total.

## Configuration

Macro: `DMEM_READ_BUF_EN`.

- **Defined:** a one-entry read buffer (tag, data, valid) is built in.
  - It is filled on every read completion.
  - A write to the tagged address updates the buffer data at the same edge that the array is written.
  - A read presented in IDLE whose address matches a valid tag is a hit:
    - `stall` stays 0;
    - `DataOut` is driven combinationally from the buffer data in that cycle;
    - the FSM stays in IDLE.
  - `init` clears the valid bit.
- **Not defined:** no buffer logic is built in; every read takes the full latency.

## Test plan

- **Reset:** assert `init` for 2 cycles → `DataOut` = 0, `stall` = 0, `mem_err` = 0, FSM in IDLE.
- **Write then read, `LATENCY` = 3:** write 16'hBEEF to address 8'h12, then read 8'h12 → each access shows exactly 4 stall cycles; `DataOut` = 16'hBEEF in the DONE cycle.
- **Address wrap, `ADDR_WIDTH` = 8:** write 16'h1234 to address 16'h0105, then read 16'h0005 → read returns 16'h1234.
- **Conflict:** assert `ReadMem` and `WriteMem` together with address 8'h20 and data 16'h00AA → `mem_err` = 1 and stays 1; a later read of 8'h20 returns 16'h00AA.
- **Reset mid-write:** assert `init` in the second BUSY cycle of a write of 16'h5555 to 8'h30, after address 8'h30 was preloaded with 16'h1111 → `stall` = 0 immediately; a subsequent read of 8'h30 returns 16'h1111.
- **Read buffer, `DMEM_READ_BUF_EN` defined:** read 8'h12 twice → the second read has 0 stall cycles and `DataOut` = 16'hBEEF in the request cycle. Then write 16'hCAFE to 8'h12 and read again → hit with `DataOut` = 16'hCAFE.
